rst_ctrl: RTL and testbench
===========================

# rst_ctrl

Tag allocator and write sequencer for the register status table (`rst`). Hands out reorder-buffer tags to dispatching instructions in circular order and retires them in order on commit. Drives the `rst` write port (`Wen_rst`/`Waddr_rst`/`Wdata_rst`) and commit-clear port (`RB_valid_rst`/`RB_tag_rst`). Optionally sequences a full-table clear after a pipeline flush.

## Interface
- `TAGS`, 32: number of tags; power of two, must match `rst` tag space
- `TAG_W`, 5: tag width, log2(`TAGS`)
- `ADDR_W`, 5: architectural register address width

- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `disp_req`  in  1  dispatch requests a destination tag
- `disp_rd`  in  `ADDR_W`  destination register of the dispatching instruction
- `disp_gnt`  out  1  tag granted this cycle
- `disp_tag`  out  `TAG_W`  tag granted (valid when `disp_gnt`)
- `cmt_valid`  in  1  ROB commits its head entry this cycle
- `cmt_tag`  out  `TAG_W`  current head tag (oldest outstanding)
- `flush`  in  1  discard all outstanding tags
- `Wen_rst`  out  1  `rst` write enable
- `Waddr_rst`  out  `ADDR_W`  `rst` write register address
- `Wdata_rst`  out  `TAG_W`  `rst` write tag
- `RB_valid_rst`  out  1  `rst` clear-by-tag strobe
- `RB_tag_rst`  out  `TAG_W`  tag to clear
- `full`, `empty`  out  1  tag pool state
- `count`  out  `TAG_W+1`  outstanding tags, 0..`TAGS`
- `busy`  out  1  high in FLUSH state

## Operation
- `head`, `tail`: `TAG_W+1`-bit counters (MSB = wrap bit). `count = tail - head` mod 2^(`TAG_W`+1). `empty = (count==0)`, `full = (count==TAGS)`.
- States: RUN, FLUSH. Reset enters RUN with `head=tail=0`.
- Dispatch (RUN): `disp_gnt = disp_req & !full & !flush`. `disp_tag = tail[TAG_W-1:0]`. On grant: `tail++`. Next cycle: `Wen_rst=1`, `Waddr_rst=disp_rd`, `Wdata_rst=` granted tag. If `disp_rd==0` (r0), the tag is still allocated but `Wen_rst` stays 0.
- Commit (RUN): `cmt_valid & !empty & !flush` pops the head: `head++`. Next cycle: `RB_valid_rst=1`, `RB_tag_rst=` old head tag. `cmt_valid` when empty is ignored.
- Simultaneous grant and commit: both take effect; `count` unchanged. `full` is evaluated before the same-cycle commit, so a dispatch while full is refused even with `cmt_valid=1`.
- Wrap-around: tag index wraps from `TAGS-1` to 0. The wrap bit distinguishes full from empty.
- Flush: see Configuration. During FLUSH, `disp_gnt=0`, commits ignored, `flush` ignored, `Wen_rst=0`.
- Reset asserted at any time aborts every operation. Counters, state and all registered outputs are forced to reset values immediately.

## Timing
- Reset values: `Wen_rst=0`, `Waddr_rst=0`, `Wdata_rst=0`, `RB_valid_rst=0`, `RB_tag_rst=0`, `busy=0`, `count=0`, `empty=1`, `full=0`, `disp_gnt=0`, `disp_tag=0`, `cmt_tag=0`.
- `disp_gnt`, `disp_tag`, `cmt_tag`: combinational from the current state/pointers and the inputs.
- `rst` port outputs: registered, asserted exactly 1 cycle after the grant or commit edge, for 1 cycle.
- Flush: `flush` sampled high at edge N. On edges N+1..N+`TAGS`, `RB_valid_rst=1` with `RB_tag_rst` = 0,1,…,`TAGS-1`. At edge N+`TAGS`, `head=tail=0` and the state returns to RUN. The first grant is possible in the cycle after edge N+`TAGS`.
- Flush at cycle N with a pending registered write from cycle N-1: that write is still emitted at N.

## Configuration
- `RST_CTRL_FLUSH_EN` defined: FLUSH state and the clear-walk sequencer are compiled in, as above.
- Not defined: `flush` is ignored and there is no FLUSH state. `busy` is tied to 0, and `disp_gnt`/commit do not qualify on `flush`.

## Test plan
- Reset release, 3 dispatches to r5, r0, r9: grants with tags 0,1,2. Writes `(5,0)`, none, `(9,2)` each 1 cycle after their grant. `count` reaches 3.
- 32 back-to-back dispatches, then a 33rd: first 32 granted with `full=1` after the 32nd. 33rd refused even with `cmt_valid=1` that cycle. Following cycle it is granted tag 0 (wrap).
- Simultaneous grant and commit at `count=4`: `count` stays 4. `RB_tag_rst` = old head and `Wdata_rst` = old tail, both emitted the next cycle.
- `cmt_valid` while empty: no `RB_valid_rst`, `head` unchanged.
- Flush with 7 outstanding (macro on): `busy=1` for 32 cycles, `RB_tag_rst` steps 0..31, then `count=0` and the next grant returns tag 0. Macro off: `flush` has no effect.
- Reset asserted mid-flush at step 10: outputs immediately take reset values. After release, the block is in RUN with tag 0 next.

Source files
------------

// File: rtl/rst_ctrl.sv
// rtl/rst_ctrl.sv - rst tag allocator and write sequencer; optional flush clear-walk under RST_CTRL_FLUSH_EN
module rst_ctrl #(
   parameter int TAGS   = 32,
   parameter int TAG_W  = 5,
   parameter int ADDR_W = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_rd,
   output logic              disp_gnt,
   output logic [TAG_W-1:0]  disp_tag,
   input  logic              cmt_valid,
   output logic [TAG_W-1:0]  cmt_tag,
   input  logic              flush,
   output logic              Wen_rst,
   output logic [ADDR_W-1:0] Waddr_rst,
   output logic [TAG_W-1:0]  Wdata_rst,
   output logic              RB_valid_rst,
   output logic [TAG_W-1:0]  RB_tag_rst,
   output logic              full,
   output logic              empty,
   output logic [TAG_W:0]    count,
   output logic              busy
);

   localparam logic [TAG_W:0]   FULL_CNT = (TAG_W+1)'(TAGS);
   localparam logic [TAG_W:0]   PTR_ONE  = (TAG_W+1)'(1);
   localparam logic [TAG_W-1:0] LAST_TAG = TAG_W'(TAGS-1);

   // head/tail carry an extra wrap bit so full and empty are distinguishable
   logic [TAG_W:0]    head_q, tail_q, head_d, tail_d;
   logic              run, flush_go, commit;
   logic              wen_d, rbv_d;
   logic [ADDR_W-1:0] waddr_d;
   logic [TAG_W-1:0]  wdata_d, rbt_d;

`ifdef RST_CTRL_FLUSH_EN
   typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;
   state_t           state_q, state_d;
   logic [TAG_W-1:0] walk_q, walk_d;

   assign run      = (state_q == RUN);
   assign flush_go = run & flush;
   assign busy     = (state_q == FLUSH);
`else
   logic unused_flush;
   assign unused_flush = flush;
   assign run      = 1'b1;
   assign flush_go = 1'b0;
   assign busy     = 1'b0;
`endif

   assign count    = tail_q - head_q;
   assign empty    = (count == '0);
   assign full     = (count == FULL_CNT);
   assign disp_tag = tail_q[TAG_W-1:0];
   assign cmt_tag  = head_q[TAG_W-1:0];
   // full is judged before any same-cycle commit, so a full pool refuses dispatch
   assign disp_gnt = run & disp_req & ~full & ~flush_go;
   assign commit   = run & cmt_valid & ~empty & ~flush_go;

   // next pointers, next state and next values of the registered rst port
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      wen_d   = disp_gnt & (disp_rd != '0);
      waddr_d = disp_gnt ? disp_rd : Waddr_rst;
      wdata_d = disp_gnt ? tail_q[TAG_W-1:0] : Wdata_rst;
      rbv_d   = commit;
      rbt_d   = commit ? head_q[TAG_W-1:0] : RB_tag_rst;
`ifdef RST_CTRL_FLUSH_EN
      state_d = state_q;
      walk_d  = walk_q;
`endif
      if (disp_gnt) tail_d = tail_q + PTR_ONE;
      if (commit)   head_d = head_q + PTR_ONE;
`ifdef RST_CTRL_FLUSH_EN
      case (state_q)
         RUN: begin
            if (flush) begin
               state_d = FLUSH;
               walk_d  = '0;
            end
         end
         FLUSH: begin
            // clear-walk: one tag per cycle, pointers restart once the last tag is cleared
            rbv_d  = 1'b1;
            rbt_d  = walk_q;
            walk_d = walk_q + TAG_W'(1);
            if (walk_q == LAST_TAG) begin
               state_d = RUN;
               head_d  = '0;
               tail_d  = '0;
            end
         end
         default: state_d = RUN;
      endcase
`endif
   end

   // state, pointers and registered rst port; reset clears everything at once
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head_q       <= '0;
         tail_q       <= '0;
         Wen_rst      <= 1'b0;
         Waddr_rst    <= '0;
         Wdata_rst    <= '0;
         RB_valid_rst <= 1'b0;
         RB_tag_rst   <= '0;
`ifdef RST_CTRL_FLUSH_EN
         state_q      <= RUN;
         walk_q       <= '0;
`endif
      end else begin
         head_q       <= head_d;
         tail_q       <= tail_d;
         Wen_rst      <= wen_d;
         Waddr_rst    <= waddr_d;
         Wdata_rst    <= wdata_d;
         RB_valid_rst <= rbv_d;
         RB_tag_rst   <= rbt_d;
`ifdef RST_CTRL_FLUSH_EN
         state_q      <= state_d;
         walk_q       <= walk_d;
`endif
      end
   end

endmodule

// File: tb/tb_rst_ctrl.sv
// tb/tb_rst_ctrl.sv - scoreboard bench for rst_ctrl
module tb_rst_ctrl;

   localparam int TAGS   = 32;
   localparam int TAG_W  = 5;
   localparam int ADDR_W = 5;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              disp_req = 1'b0;
   logic [ADDR_W-1:0] disp_rd = '0;
   logic              disp_gnt;
   logic [TAG_W-1:0]  disp_tag;
   logic              cmt_valid = 1'b0;
   logic [TAG_W-1:0]  cmt_tag;
   logic              flush = 1'b0;
   logic              Wen_rst;
   logic [ADDR_W-1:0] Waddr_rst;
   logic [TAG_W-1:0]  Wdata_rst;
   logic              RB_valid_rst;
   logic [TAG_W-1:0]  RB_tag_rst;
   logic              full, empty, busy;
   logic [TAG_W:0]    count;

   rst_ctrl #(.TAGS(TAGS), .TAG_W(TAG_W), .ADDR_W(ADDR_W)) dut (
      .clock(clock), .reset(reset),
      .disp_req(disp_req), .disp_rd(disp_rd), .disp_gnt(disp_gnt), .disp_tag(disp_tag),
      .cmt_valid(cmt_valid), .cmt_tag(cmt_tag), .flush(flush),
      .Wen_rst(Wen_rst), .Waddr_rst(Waddr_rst), .Wdata_rst(Wdata_rst),
      .RB_valid_rst(RB_valid_rst), .RB_tag_rst(RB_tag_rst),
      .full(full), .empty(empty), .count(count), .busy(busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      int cyc;
      int a;
      int t;
   } ev_t;

   ev_t wr_q[$];
   ev_t clr_q[$];
   int  checks = 0;
   int  failures = 0;
   int  cyc = 0;
   int  m_head = 0;
   int  m_tail = 0;
   int  m_walk = 0;
   bit  m_run = 1'b1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push_ev(input bit is_wr, input int c, input int a, input int t);
      ev_t e;
      e.cyc = c;
      e.a   = a;
      e.t   = t;
      if (is_wr) wr_q.push_back(e);
      else       clr_q.push_back(e);
   endtask

   task automatic scan_outputs();
      ev_t e;
      if (Wen_rst) begin
         if (wr_q.size() == 0) check("wen_spurious", 1, 0);
         else begin
            e = wr_q.pop_front();
            check("wen_cycle", cyc, e.cyc);
            check("waddr", 32'(Waddr_rst), e.a);
            check("wdata", 32'(Wdata_rst), e.t);
         end
      end else if (wr_q.size() > 0 && wr_q[0].cyc <= cyc) begin
         check("wen_missing", 0, 1);
         void'(wr_q.pop_front());
      end
      if (RB_valid_rst) begin
         if (clr_q.size() == 0) check("rbv_spurious", 1, 0);
         else begin
            e = clr_q.pop_front();
            check("rbv_cycle", cyc, e.cyc);
            check("rb_tag", 32'(RB_tag_rst), e.t);
         end
      end else if (clr_q.size() > 0 && clr_q[0].cyc <= cyc) begin
         check("rbv_missing", 0, 1);
         void'(clr_q.pop_front());
      end
   endtask

   // drive one cycle of inputs, check combinational outputs against the model, clock, scan rst port
   task automatic step(input bit req, input int rd, input bit cv, input bit fl);
      int cnt;
      bit gnt, com, fl_eff;
      disp_req  = req;
      disp_rd   = ADDR_W'(rd);
      cmt_valid = cv;
      flush     = fl;
      #1;
`ifdef RST_CTRL_FLUSH_EN
      fl_eff = fl;
`else
      fl_eff = 1'b0;
`endif
      cnt = (m_tail - m_head + 2*TAGS) % (2*TAGS);
      check("count", 32'(count), cnt);
      check("empty", 32'(empty), 32'(cnt == 0));
      check("full", 32'(full), 32'(cnt == TAGS));
      check("busy", 32'(busy), 32'(!m_run));
      check("cmt_tag", 32'(cmt_tag), m_head % TAGS);
      if (m_run) begin
         gnt = req && (cnt != TAGS) && !fl_eff;
         com = cv && (cnt != 0) && !fl_eff;
         check("disp_gnt", 32'(disp_gnt), 32'(gnt));
         if (gnt) begin
            check("disp_tag", 32'(disp_tag), m_tail % TAGS);
            if (rd != 0) push_ev(1'b1, cyc + 1, rd, m_tail % TAGS);
            m_tail = (m_tail + 1) % (2*TAGS);
         end
         if (com) begin
            push_ev(1'b0, cyc + 1, 0, m_head % TAGS);
            m_head = (m_head + 1) % (2*TAGS);
         end
         if (fl_eff) begin
            m_run  = 1'b0;
            m_walk = 0;
         end
      end else begin
         check("disp_gnt_flush", 32'(disp_gnt), 0);
         push_ev(1'b0, cyc + 1, 0, m_walk);
         m_walk++;
         if (m_walk == TAGS) begin
            m_head = 0;
            m_tail = 0;
            m_run  = 1'b1;
         end
      end
      @(posedge clock);
      #1;
      cyc++;
      scan_outputs();
   endtask

   // assert reset between edges and confirm the outputs fall to reset values before any edge
   task automatic do_reset();
      disp_req  = 1'b0;
      cmt_valid = 1'b0;
      flush     = 1'b0;
      disp_rd   = '0;
      reset     = 1'b0;
      #1;
      check("rst_wen", 32'(Wen_rst), 0);
      check("rst_waddr", 32'(Waddr_rst), 0);
      check("rst_wdata", 32'(Wdata_rst), 0);
      check("rst_rbv", 32'(RB_valid_rst), 0);
      check("rst_rbtag", 32'(RB_tag_rst), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_count", 32'(count), 0);
      check("rst_empty", 32'(empty), 1);
      check("rst_full", 32'(full), 0);
      check("rst_gnt", 32'(disp_gnt), 0);
      check("rst_disp_tag", 32'(disp_tag), 0);
      check("rst_cmt_tag", 32'(cmt_tag), 0);
      wr_q.delete();
      clr_q.delete();
      m_head = 0;
      m_tail = 0;
      m_walk = 0;
      m_run  = 1'b1;
      @(posedge clock);
      #1;
      cyc++;
      check("rst_hold_rbv", 32'(RB_valid_rst), 0);
      reset = 1'b1;
   endtask

   initial begin
      #2;
      do_reset();
      step(0, 0, 0, 0);

      // three dispatches: r5, r0 (no write), r9
      step(1, 5, 0, 0);
      step(1, 0, 0, 0);
      step(1, 9, 0, 0);
      step(0, 0, 0, 0);
      check("count_after3", 32'(count), 3);

      // drain, then commit while empty
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      check("cmt_tag_empty", 32'(cmt_tag), 3);

      // fill to full, refused 33rd with commit, then wrap to tag 0
      do_reset();
      for (int i = 0; i < TAGS; i++) step(1, int'($urandom_range(0, 31)), 0, 0);
      check("full_after32", 32'(full), 1);
      step(1, 17, 1, 0);
      step(1, 18, 0, 0);
      step(0, 0, 0, 0);

      // simultaneous grant and commit at count 4
      do_reset();
      for (int i = 0; i < 4; i++) step(1, i + 1, 0, 0);
      step(1, 7, 1, 0);
      check("count_gc", 32'(count), 4);
      step(0, 0, 0, 0);

      // mixed random traffic
      for (int i = 0; i < 60; i++)
         step(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 0);
      for (int i = 0; i < 40; i++) step(0, 0, 1, 0);

      // flush with 7 outstanding; flush asserted again mid-walk is ignored
      do_reset();
      for (int i = 0; i < 7; i++) step(1, 20 + i, 0, 0);
      step(1, 3, 1, 1);
      for (int i = 0; i < TAGS; i++)
         step(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      step(1, 3, 0, 0);
      step(0, 0, 0, 0);

      // reset in the middle of a flush walk (or of ordinary traffic without the flush build)
      do_reset();
      for (int i = 0; i < 3; i++) step(1, 11, 0, 0);
      step(0, 0, 0, 1);
      for (int i = 0; i < 10; i++) step(1, 12, 1, 0);
      do_reset();
      step(1, 4, 0, 0);
      check("tag0_after_rst", 32'(m_tail), 1);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0);

      check("wr_q_drained", 32'(wr_q.size()), 0);
      check("clr_q_drained", 32'(clr_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      failures++;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
